// File: rtl/vga_sync_ctrl.sv
// VGA raster timing sequencer: pixel-rate strobe from a clock divider, horizontal and
// vertical position counters, and zero-latency sync/visible/strobe decodes of those counters.
module vga_sync_ctrl #(
    parameter int   CNT_W     = 10,
    parameter int   CLK_DIV   = 2,
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_en,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_visible,
    output logic             o_line_end,
    output logic             o_frame_end
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;

    logic w_pix_en;
    logic w_h_last;
    logic w_v_last;
    logic w_hs_act;
    logic w_vs_act;

    // The strobe is gated by i_en combinationally, so dropping i_en while the divider
    // sits on its last phase suppresses that pixel and it is issued once i_en returns.
    assign w_pix_en = i_en & (r_div == DIV_LAST);
    assign w_h_last = (r_hcnt == H_LAST);
    assign w_v_last = (r_vcnt == V_LAST);

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            if (i_en) begin
                r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
            end
            if (w_pix_en) begin
                r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
                if (w_h_last) begin
                    r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
                end
            end
        end
    end

    assign w_hs_act = (r_hcnt >= HS_START) && (r_hcnt < HS_END);
    assign w_vs_act = (r_vcnt >= VS_START) && (r_vcnt < VS_END);

    assign o_pix_en    = w_pix_en;
    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_hsync     = w_hs_act ? HSYNC_POL : ~HSYNC_POL;
    assign o_vsync     = w_vs_act ? VSYNC_POL : ~VSYNC_POL;
    assign o_visible   = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    assign o_line_end  = w_pix_en & w_h_last;
    assign o_frame_end = w_pix_en & w_h_last & w_v_last;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl on a tiny raster (8x6 positions, 2 clocks per pixel): directed
// vector table, hand-written freeze/reset sequences and random enable/reset traffic.
module tb_vga_sync_ctrl;

    localparam int CNT_W   = 10;
    localparam int CLK_DIV = 2;
    localparam int H_VIS   = 4;
    localparam int H_FP    = 1;
    localparam int H_SW    = 2;
    localparam int H_BP    = 1;
    localparam int V_VIS   = 3;
    localparam int V_FP    = 1;
    localparam int V_SW    = 1;
    localparam int V_BP    = 1;
    localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
    localparam int PERIOD  = CLK_DIV * H_TOTAL * V_TOTAL;
    localparam int W       = 2 * CNT_W + 6;

    // ---------------- clock / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_sclr;
    logic             i_en;
    logic             o_pix_en;
    logic [CNT_W-1:0] o_hcnt;
    logic [CNT_W-1:0] o_vcnt;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_visible;
    logic             o_line_end;
    logic             o_frame_end;

    vga_sync_ctrl #(
        .CNT_W(CNT_W), .CLK_DIV(CLK_DIV),
        .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SW), .H_BACK(H_BP),
        .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SW), .V_BACK(V_BP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .i_sclr(i_sclr), .i_en(i_en),
        .o_pix_en(o_pix_en), .o_hcnt(o_hcnt), .o_vcnt(o_vcnt),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_visible(o_visible),
        .o_line_end(o_line_end), .o_frame_end(o_frame_end)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference: count enabled clocks since reset; pixel number and raster position follow by division.
    int m_clks = 0;
    int m_h = 0;
    int m_v = 0;

    function automatic logic [W-1:0] pack(input logic pix, input int h, input int v,
                                          input logic hs, input logic vs, input logic vis,
                                          input logic le, input logic fe);
        return {pix, CNT_W'(h), CNT_W'(v), hs, vs, vis, le, fe};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {o_pix_en, o_hcnt, o_vcnt, o_hsync, o_vsync, o_visible, o_line_end, o_frame_end};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got pix=%b h=%0d v=%0d hs/vs/vis/le/fe=%b, expected pix=%b h=%0d v=%0d hs/vs/vis/le/fe=%b",
                     name, act[W-1], act[W-2 -: CNT_W], act[W-2-CNT_W -: CNT_W], act[4:0],
                     exp[W-1], exp[W-2 -: CNT_W], exp[W-2-CNT_W -: CNT_W], exp[4:0]);
        end
    endtask

    task automatic model_push(input logic sclr, input logic en);
        int pix_num;
        int phase;
        logic pix, hs, vs, vis, le, fe;
        if (sclr) m_clks = 0;
        else if (en) m_clks = (m_clks + 1) % PERIOD;
        pix_num = m_clks / CLK_DIV;
        phase   = m_clks % CLK_DIV;
        m_h     = pix_num % H_TOTAL;
        m_v     = (pix_num / H_TOTAL) % V_TOTAL;
        pix = en && (phase == CLK_DIV - 1);
        hs  = !(m_h >= H_VIS + H_FP && m_h < H_VIS + H_FP + H_SW);
        vs  = !(m_v >= V_VIS + V_FP && m_v < V_VIS + V_FP + V_SW);
        vis = (m_h < H_VIS) && (m_v < V_VIS);
        le  = pix && (m_h == H_TOTAL - 1);
        fe  = le && (m_v == V_TOTAL - 1);
        exp_q.push_back(pack(pix, m_h, m_v, hs, vs, vis, le, fe));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic sclr, input logic en);
        i_sclr = sclr;
        i_en   = en;
        @(posedge clk);
        #1;
        model_push(sclr, en);
        check("model", dut_vec(), exp_q.pop_front());
    endtask

    typedef struct {
        logic         sclr;
        logic         en;
        int           edges;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit found;
        i_sclr = 1'b1;
        i_en   = 1'b1;

        // Cumulative edge counts from reset release are noted per entry.
        vecs[0]  = '{1'b1, 1'b1, 2,  pack(0, 0, 0, 1, 1, 1, 0, 0)};  // reset held
        vecs[1]  = '{1'b0, 1'b1, 1,  pack(1, 0, 0, 1, 1, 1, 0, 0)};  // edge 1
        vecs[2]  = '{1'b0, 1'b1, 1,  pack(0, 1, 0, 1, 1, 1, 0, 0)};  // edge 2
        vecs[3]  = '{1'b0, 1'b1, 6,  pack(0, 4, 0, 1, 1, 0, 0, 0)};  // edge 8
        vecs[4]  = '{1'b0, 1'b1, 2,  pack(0, 5, 0, 0, 1, 0, 0, 0)};  // edge 10
        vecs[5]  = '{1'b0, 1'b1, 3,  pack(1, 6, 0, 0, 1, 0, 0, 0)};  // edge 13
        vecs[6]  = '{1'b0, 1'b1, 2,  pack(1, 7, 0, 1, 1, 0, 1, 0)};  // edge 15
        vecs[7]  = '{1'b0, 1'b1, 1,  pack(0, 0, 1, 1, 1, 1, 0, 0)};  // edge 16
        vecs[8]  = '{1'b0, 1'b1, 48, pack(0, 0, 4, 1, 0, 0, 0, 0)};  // edge 64
        vecs[9]  = '{1'b0, 1'b1, 31, pack(1, 7, 5, 1, 1, 0, 1, 1)};  // edge 95
        vecs[10] = '{1'b0, 1'b1, 1,  pack(0, 0, 0, 1, 1, 1, 0, 0)};  // edge 96

        for (int i = 0; i < 11; i++) begin
            for (int e = 0; e < vecs[i].edges; e++) step(vecs[i].sclr, vecs[i].en);
            check($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
        end

        // Freeze on the even phase, then resume with the same cadence.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check("freeze_pre", dut_vec(), pack(0, 3, 0, 1, 1, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check("freeze_hold", dut_vec(), pack(0, 3, 0, 1, 1, 1, 0, 0));
        end
        step(1'b0, 1'b1);
        check("resume_phase", dut_vec(), pack(1, 3, 0, 1, 1, 1, 0, 0));
        step(1'b0, 1'b1);
        check("resume_adv", dut_vec(), pack(0, 4, 0, 1, 1, 0, 0, 0));

        // Freeze on the strobe phase: the strobe is withheld and issued after resume.
        step(1'b0, 1'b1);
        check("odd_pre", dut_vec(), pack(1, 4, 0, 1, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("odd_hold", dut_vec(), pack(0, 4, 0, 1, 1, 0, 0, 0));
        end
        step(1'b0, 1'b1);
        check("odd_resume", dut_vec(), pack(0, 5, 0, 0, 1, 0, 0, 0));

        // Mid-frame reset at v=2, h=6.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1'b0, 1'b1);
            if (m_v == 2 && m_h == 6) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL midframe_reach: got no v=2 h=6 within 200 cycles, expected to reach it");
        end
        step(1'b1, 1'b1);
        check("midframe_reset", dut_vec(), pack(0, 0, 0, 1, 1, 1, 0, 0));
        step(1'b0, 1'b1);
        check("post_reset", dut_vec(), pack(1, 0, 0, 1, 1, 1, 0, 0));

        // Random enable and occasional reset traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
